// File: rtl/restoring_divider_core.sv
// Sequential unsigned restoring divider.
// A division is accepted from IDLE on start. One quotient bit is produced per
// clock over WIDTH CALC cycles. A single DONE cycle follows, which pulses done
// and loads the Q/R/dbz result registers.
module restoring_divider_core #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic             ready,
    output logic             done,
    output logic             dbz
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] qsr;
    logic [WIDTH-1:0] divisor;
    // The partial remainder is always below the divisor between iterations,
    // so its top bit is structurally zero. Only WIDTH bits are kept. The
    // WIDTH+1-bit form exists only in the shifted value and in the trial.
    logic [WIDTH-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic             pend_dbz;

    logic [WIDTH:0]   shift_rem;
    logic [WIDTH:0]   trial;
    logic             last_iter;

    // Trial subtraction in WIDTH+1 bits. The MSB set means the divisor did not fit.
    function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0]   r,
                                                 input logic [WIDTH-1:0] d);
        return r - {1'b0, d};
    endfunction

    // Shift the remainder and quotient pair left by one, then form the trial difference.
    always_comb begin
        shift_rem = {rem, qsr[WIDTH-1]};
        trial     = trial_sub(shift_rem, divisor);
        last_iter = (cnt == CNT_W'(WIDTH - 1));
    end

    assign ready = (state == S_IDLE);
    assign done  = (state == S_DONE);

    // Sequencing: IDLE accepts, CALC iterates WIDTH times, DONE lasts one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CALC;
                        cnt   <= '0;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Working registers: capture operands on accept, then one restoring step per CALC cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qsr      <= '0;
            divisor  <= '0;
            rem      <= '0;
            pend_dbz <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                qsr      <= A;
                divisor  <= B;
                pend_dbz <= (B == '0);
                rem      <= '0;
            end else if (state == S_CALC) begin
                // A negative trial restores the shifted remainder. That can only
                // happen when the shifted value is below 2^WIDTH, so dropping
                // its top bit is lossless.
                if (trial[WIDTH]) begin
                    rem <= shift_rem[WIDTH-1:0];
                end else begin
                    rem <= trial[WIDTH-1:0];
                end
                qsr <= {qsr[WIDTH-2:0], ~trial[WIDTH]};
            end
        end
    end

    // Result registers: loaded on leaving DONE and held until the next completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Q   <= '0;
            R   <= '0;
            dbz <= 1'b0;
        end else if (state == S_DONE) begin
            Q   <= qsr;
            R   <= rem;
            dbz <= pend_dbz;
        end
    end

endmodule

// File: tb/tb_restoring_divider_core.sv
// Bench for restoring_divider_core. Directed scenarios with literal
// expectations are followed by randomized start/operand traffic. All of it is
// compared every cycle against a latency-level behavioural model.
module tb_restoring_divider_core;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;
    localparam int LAT   = WIDTH + 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] Q;
    logic             ready;
    logic             done;
    logic             dbz;

    int n_checks = 0;
    int n_pass   = 0;

    restoring_divider_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .R     (R),
        .Q     (Q),
        .ready (ready),
        .done  (done),
        .dbz   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference division: {dbz, quotient, remainder}. Divide by zero yields all ones and A.
    function automatic logic [2*WIDTH:0] ref_div(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        if (b == '0) return {1'b1, {WIDTH{1'b1}}, a};
        return {1'b0, a / b, a % b};
    endfunction

    // Behavioural model: m_cyc counts the cycles since acceptance (0 = available).
    int               m_cyc;
    logic [WIDTH-1:0] m_q, m_r, p_q, p_r;
    logic             m_dbz, p_dbz;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cyc <= 0;
            m_q   <= '0;
            m_r   <= '0;
            m_dbz <= 1'b0;
        end else if (m_cyc == 0) begin
            if (start) begin
                m_cyc <= 1;
                {p_dbz, p_q, p_r} <= ref_div(A, B);
            end
        end else if (m_cyc == LAT) begin
            m_cyc <= 0;
            m_q   <= p_q;
            m_r   <= p_r;
            m_dbz <= p_dbz;
        end else begin
            m_cyc <= m_cyc + 1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("ready_vs_model", 32'(ready), 32'(m_cyc == 0));
        check("done_vs_model",  32'(done),  32'(m_cyc == LAT));
        check("Q_vs_model",     32'(Q),     32'(m_q));
        check("R_vs_model",     32'(R),     32'(m_r));
        check("dbz_vs_model",   32'(dbz),   32'(m_dbz));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one accepting edge. On return the bench is in CALC cycle 1.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        A     = a;
        B     = b;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Count cycles (starting with the current one as 1) until done is seen, bounded.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    // Step past DONE and check the committed result and the return of ready.
    task automatic expect_result(input string name, input logic [WIDTH-1:0] eq,
                                 input logic [WIDTH-1:0] er, input logic ed);
        cyc();
        check({name, "_Q"},     32'(Q),     32'(eq));
        check({name, "_R"},     32'(R),     32'(er));
        check({name, "_dbz"},   32'(dbz),   32'(ed));
        check({name, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int lat;
        int dones;
        rst   = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) cyc();
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done",  32'(done),  32'd0);
        check("reset_Q",     32'(Q),     32'd0);
        check("reset_R",     32'(R),     32'd0);
        check("reset_dbz",   32'(dbz),   32'd0);
        rst = 1'b1;
        cyc();

        // 1000 / 7
        launch(16'd1000, 16'd7);
        check("t1_ready_drops", 32'(ready), 32'd0);
        wait_done(lat);
        check("t1_latency", 32'(lat), 32'(LAT));
        expect_result("t1", 16'd142, 16'd6, 1'b0);
        check("t1_model_q", 32'(m_q), 32'd142);
        check("t1_model_r", 32'(m_r), 32'd6);

        // Full-scale operands exercise the extra trial bit
        launch(16'hFFFF, 16'hFFFF);
        wait_done(lat);
        check("t2a_latency", 32'(lat), 32'(LAT));
        expect_result("t2a", 16'h0001, 16'h0000, 1'b0);
        launch(16'hFFFF, 16'h0001);
        wait_done(lat);
        expect_result("t2b", 16'hFFFF, 16'h0000, 1'b0);

        // Back-to-back with start held high through IDLE
        A = 16'd5; B = 16'd9; start = 1'b1;
        cyc();
        A = 16'd50000; B = 16'd300;
        wait_done(lat);
        check("t3a_latency", 32'(lat), 32'(LAT));
        expect_result("t3a", 16'd0, 16'd5, 1'b0);
        cyc();
        start = 1'b0;
        check("t3_rerun_busy", 32'(ready), 32'd0);
        wait_done(lat);
        check("t3b_latency", 32'(lat), 32'(LAT));
        expect_result("t3b", 16'd166, 16'd200, 1'b0);

        // Divide by zero, then a normal division clears the flag
        launch(16'h1234, 16'h0000);
        wait_done(lat);
        check("t4a_latency", 32'(lat), 32'(LAT));
        expect_result("t4a", 16'hFFFF, 16'h1234, 1'b1);
        check("t4a_model_dbz", 32'(m_dbz), 32'd1);
        launch(16'd20, 16'd4);
        wait_done(lat);
        expect_result("t4b", 16'd5, 16'd0, 1'b0);

        // start pulse with new operands during CALC cycle 5 is ignored
        launch(16'd100, 16'd3);
        repeat (4) cyc();
        A = 16'd1; B = 16'd1; start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done(lat);
        check("t5_latency_from_c6", 32'(lat), 32'(LAT - 5));
        expect_result("t5", 16'd33, 16'd1, 1'b0);
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("t5_no_second_done", 32'(dones), 32'd0);
        cyc();

        // Reset in CALC cycle 8 aborts, then a full-latency run
        launch(16'd77, 16'd7);
        repeat (7) cyc();
        rst = 1'b0;
        #1;
        check("t6_rst_ready", 32'(ready), 32'd1);
        check("t6_rst_done",  32'(done),  32'd0);
        check("t6_rst_Q",     32'(Q),     32'd0);
        check("t6_rst_R",     32'(R),     32'd0);
        cyc();
        cyc();
        rst = 1'b1;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("t6_no_done_after_abort", 32'(dones), 32'd0);
        cyc();
        launch(16'd77, 16'd7);
        wait_done(lat);
        check("t6_latency", 32'(lat), 32'(LAT));
        expect_result("t6", 16'd11, 16'd0, 1'b0);

        // Randomized traffic: random start levels, operands that change every cycle, rare resets
        for (int i = 0; i < 4000; i++) begin
            int sel;
            sel   = int'($urandom_range(0, 9));
            start = ($urandom_range(0, 2) == 0);
            A     = WIDTH'($urandom);
            if (sel == 0)      B = '0;
            else if (sel < 4)  B = WIDTH'($urandom_range(1, 15));
            else if (sel < 6)  B = WIDTH'($urandom_range(256, 4095));
            else               B = WIDTH'($urandom);
            if ($urandom_range(0, 599) == 0) rst = 1'b0;
            else                             rst = 1'b1;
            cyc();
        end
        rst   = 1'b1;
        start = 1'b0;
        repeat (25) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
